vec_reg_file: RTL and testbench
===============================

# vec_reg_file

Parametrised vector register file for the vector processor datapath, successor to the fixed 4×512 register file. Holds NUM_REGS vector registers of VLEN bits, serves two registered read ports to the ALU, two ALU writeback ports, and a load port and a store port with valid/ready handshakes to the memory interface. All state is clocked, with defined write priority, read bypass and a preset image for bring-up.

## Interface

**Parameters**
- VLEN, 512, vector register width in bits
- NUM_REGS, 4, number of vector registers (≥2)
- AW, $clog2(NUM_REGS), register address width

**Ports**
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- preset  in  1  load preset image into all registers (one cycle)
- rd_en  in  1  capture read ports this cycle
- rd_addr_a, rd_addr_b  in  AW  read addresses
- rd_data_a, rd_data_b  out  VLEN  registered read data
- rd_valid  out  1  read data valid (one-cycle pulse)
- wr_en_a, wr_en_b  in  1  ALU writeback enables
- wr_addr_a, wr_addr_b  in  AW  writeback addresses
- wr_data_a, wr_data_b  in  VLEN  writeback data
- ld_valid  in  1  load data offered
- ld_ready  out  1  load accepted when valid && ready
- ld_addr  in  AW  load destination register
- ld_data  in  VLEN  load data
- st_req  in  1  store request
- st_req_ready  out  1  store request accepted when st_req && st_req_ready
- st_addr  in  AW  store source register
- st_valid  out  1  store data valid
- st_ready  in  1  memory side accepts store data
- st_data  out  VLEN  store data, held while st_valid && !st_ready

## Operation

- Reset (reset=0, asynchronous): all registers 0; rd_data_a/b, st_data = 0; rd_valid, st_valid = 0. ld_ready = 0 while reset is asserted.
- Preset: registers 0 and 1 = {1'b1, (VLEN-1)'b0}; register k≥2 = 1000·(k−1), zero-extended (4 regs: 1000, 2000). Preset overrides every write source that cycle. ld_ready = 0 during a preset cycle.
- Write sources per cycle: load (ld_valid && ld_ready), wr_b, wr_a. All may write distinct addresses in the same cycle. On an address collision: preset > load > wr_b > wr_a. Losing writes are dropped silently.
- Out-of-range address (NUM_REGS not a power of two): writes are ignored, reads return 0.
- Read (rd_en): rd_data_x ← the value the register holds after this cycle's writes (write-first bypass, with the same priority). rd_valid pulses 1 the following cycle. Without rd_en, rd_data holds its value and rd_valid = 0.
- Store path: a one-entry output buffer.
  - st_req_ready = !st_valid || st_ready.
  - On accept, st_data ← bypassed value of st_addr, and st_valid ← 1.
  - st_valid clears on st_ready unless a new request is accepted in the same cycle (back-to-back).
  - st_data is stable while st_valid && !st_ready.
- ld_ready = 1 outside reset and preset.

## Timing

- Write latency: 1 cycle. A value written at edge N is readable from the array at cycle N+1, or in the same cycle through the bypass.
- Read latency: 1 cycle, from rd_en to rd_data/rd_valid.
- Store latency: 1 cycle, from accepted st_req to st_valid. Sustained throughput is 1 store per cycle when st_ready=1.
- Reset asserted mid-store: st_valid drops immediately (asynchronous) and the pending data is lost.
- Preset with a concurrent rd_en or st_req: the read or store returns the preset values.

## Structure

- Shared package vp_pkg: VLEN default, preset constants (PRESET_MSB_REG, PRESET_STEP = 1000), and the write-priority encoding.
- Sub-module vrf_store_buf: the one-entry valid/ready output buffer. The register array, priority mux and bypass stay in vec_reg_file.

## Test plan

- Reset, then preset, then read 2/3 → rd_data_a=1000 and rd_data_b=2000 one cycle after rd_en; read 0 → MSB=1, rest 0.
- wr_a (r1, 0x5) and wr_b (r1, 0x9) in the same cycle, then read r1 → 0x9. Repeat adding a load of 0x7 to r1 → 0x7.
- rd_en on r2 in the same cycle as wr_a(r2, 0xABC) → rd_data_a=0xABC next cycle (bypass).
- st_req on r3 with st_ready=0 for 3 cycles → st_valid=1, st_data=2000 held, st_req_ready=0. Raise st_ready with a new st_req on r2 → back-to-back, st_data=1000.
- ld_valid asserted during preset → ld_ready=0 and no write. In the next cycle, ld (r0, 0x1234) → read r0 returns 0x1234.
- Assert reset with st_valid=1 mid-transfer → st_valid=0 and st_data=0 immediately. After release, all reads return 0.

Source files
------------

// File: rtl/vp_pkg.sv
// Shared constants for the vector processor datapath: widths, the preset image,
// and the per-register write-source priority encoding.
package vp_pkg;

    localparam int unsigned VLEN_DEFAULT   = 512;
    // Registers 0..PRESET_MSB_REG preset to MSB-only; the rest to PRESET_STEP*(k-1).
    localparam int unsigned PRESET_MSB_REG = 1;
    localparam int unsigned PRESET_STEP    = 1000;

    typedef enum logic [2:0] {
        SrcHold,
        SrcWrA,
        SrcWrB,
        SrcLoad,
        SrcPreset
    } wr_src_e;

    // Resolves the winning write source for one register: preset > load > wr_b > wr_a.
    function automatic wr_src_e wr_src_sel(input logic preset, input logic ld_hit,
                                           input logic wb_hit, input logic wa_hit);
        if (preset) begin
            return SrcPreset;
        end else if (ld_hit) begin
            return SrcLoad;
        end else if (wb_hit) begin
            return SrcWrB;
        end else if (wa_hit) begin
            return SrcWrA;
        end
        return SrcHold;
    endfunction

endpackage

// File: rtl/vrf_store_buf.sv
// One-entry valid/ready output buffer for the store path. Data is captured on an
// accepted request and held until the memory side takes it.
module vrf_store_buf
    import vp_pkg::*;
#(
    parameter int unsigned VLEN = VLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            st_req,
    output logic            st_req_ready,
    input  logic [VLEN-1:0] data_in,
    output logic            st_valid,
    input  logic            st_ready,
    output logic [VLEN-1:0] st_data
);

    logic            valid_q, valid_d;
    logic [VLEN-1:0] data_q, data_d;
    logic            accept;

    assign st_req_ready = !valid_q || st_ready;
    assign accept       = st_req && st_req_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = data_in;
        end else if (st_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign st_valid = valid_q;
    assign st_data  = data_q;

endmodule

// File: rtl/vec_reg_file.sv
// Parametrised vector register file: two registered read ports, two ALU writeback
// ports, a load port and a buffered store port, all reading through a write-first bypass.
module vec_reg_file
    import vp_pkg::*;
#(
    parameter int unsigned VLEN     = VLEN_DEFAULT,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            preset,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr_a,
    input  logic [AW-1:0]   rd_addr_b,
    output logic [VLEN-1:0] rd_data_a,
    output logic [VLEN-1:0] rd_data_b,
    output logic            rd_valid,
    input  logic            wr_en_a,
    input  logic            wr_en_b,
    input  logic [AW-1:0]   wr_addr_a,
    input  logic [AW-1:0]   wr_addr_b,
    input  logic [VLEN-1:0] wr_data_a,
    input  logic [VLEN-1:0] wr_data_b,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW-1:0]   ld_addr,
    input  logic [VLEN-1:0] ld_data,
    input  logic            st_req,
    output logic            st_req_ready,
    input  logic [AW-1:0]   st_addr,
    output logic            st_valid,
    input  logic            st_ready,
    output logic [VLEN-1:0] st_data
);

    localparam int unsigned NUM_SLOTS = 1 << AW;

    logic [VLEN-1:0] regs_q     [NUM_REGS];
    logic [VLEN-1:0] regs_d     [NUM_REGS];
    logic [VLEN-1:0] preset_img [NUM_REGS];
    // Post-write view of every addressable slot; unimplemented slots read as zero.
    logic [VLEN-1:0] rd_view    [NUM_SLOTS];

    logic [VLEN-1:0] rd_data_a_q, rd_data_a_d;
    logic [VLEN-1:0] rd_data_b_q, rd_data_b_d;
    logic            rd_valid_q;
    logic            ld_fire;

    assign ld_ready = reset && !preset;
    assign ld_fire  = ld_valid && ld_ready;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_preset
        if (k <= PRESET_MSB_REG) begin : g_msb
            assign preset_img[k] = {1'b1, {(VLEN-1){1'b0}}};
        end else begin : g_step
            assign preset_img[k] = VLEN'(PRESET_STEP * (k - 1));
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            case (wr_src_sel(preset,
                             ld_fire && (ld_addr == AW'(i)),
                             wr_en_b && (wr_addr_b == AW'(i)),
                             wr_en_a && (wr_addr_a == AW'(i))))
                SrcPreset: regs_d[i] = preset_img[i];
                SrcLoad:   regs_d[i] = ld_data;
                SrcWrB:    regs_d[i] = wr_data_b;
                SrcWrA:    regs_d[i] = wr_data_a;
                default:   regs_d[i] = regs_q[i];
            endcase
        end
    end

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_view
        if (s < NUM_REGS) begin : g_impl
            assign rd_view[s] = regs_d[s];
        end else begin : g_hole
            assign rd_view[s] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        if (rd_en) begin
            rd_data_a_d = rd_view[rd_addr_a];
            rd_data_b_d = rd_view[rd_addr_b];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            rd_valid_q  <= rd_en;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign rd_valid  = rd_valid_q;

    vrf_store_buf #(
        .VLEN(VLEN)
    ) u_store_buf (
        .clk         (clk),
        .reset       (reset),
        .st_req      (st_req),
        .st_req_ready(st_req_ready),
        .data_in     (rd_view[st_addr]),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_data     (st_data)
    );

endmodule

// File: tb/tb_vec_reg_file.sv
// Directed bench for vec_reg_file: a per-cycle vector table for the read/write/preset
// paths, hand sequences for the store buffer and reset, and a 3-register instance.
module tb_vec_reg_file;

    localparam int unsigned VLEN  = 512;
    localparam int unsigned NREGS = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned VLEN2 = 16;

    logic            clk;
    logic            reset;
    logic            preset;
    logic            rd_en;
    logic [AW-1:0]   rd_addr_a, rd_addr_b;
    logic [VLEN-1:0] rd_data_a, rd_data_b;
    logic            rd_valid;
    logic            wr_en_a, wr_en_b;
    logic [AW-1:0]   wr_addr_a, wr_addr_b;
    logic [VLEN-1:0] wr_data_a, wr_data_b;
    logic            ld_valid, ld_ready;
    logic [AW-1:0]   ld_addr;
    logic [VLEN-1:0] ld_data;
    logic            st_req, st_req_ready;
    logic [AW-1:0]   st_addr;
    logic            st_valid, st_ready;
    logic [VLEN-1:0] st_data;

    // Second instance with a non-power-of-two register count.
    logic             s_rd_en, s_rd_valid;
    logic [1:0]       s_rd_addr_a, s_rd_addr_b;
    logic [VLEN2-1:0] s_rd_data_a, s_rd_data_b;
    logic             s_wr_en_a, s_wr_en_b;
    logic [1:0]       s_wr_addr_a, s_wr_addr_b;
    logic [VLEN2-1:0] s_wr_data_a, s_wr_data_b;
    logic             s_ld_ready, s_st_req_ready, s_st_valid;
    logic [VLEN2-1:0] s_st_data;

    int total;
    int bad;

    localparam logic [VLEN-1:0] MSB = {1'b1, {(VLEN-1){1'b0}}};

    vec_reg_file #(.VLEN(VLEN), .NUM_REGS(NREGS), .AW(AW)) dut (
        .clk(clk), .reset(reset), .preset(preset),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid),
        .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .st_req(st_req), .st_req_ready(st_req_ready), .st_addr(st_addr),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data)
    );

    vec_reg_file #(.VLEN(VLEN2), .NUM_REGS(3), .AW(2)) dut3 (
        .clk(clk), .reset(reset), .preset(1'b0),
        .rd_en(s_rd_en), .rd_addr_a(s_rd_addr_a), .rd_addr_b(s_rd_addr_b),
        .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b), .rd_valid(s_rd_valid),
        .wr_en_a(s_wr_en_a), .wr_en_b(s_wr_en_b),
        .wr_addr_a(s_wr_addr_a), .wr_addr_b(s_wr_addr_b),
        .wr_data_a(s_wr_data_a), .wr_data_b(s_wr_data_b),
        .ld_valid(1'b0), .ld_ready(s_ld_ready), .ld_addr(2'd0), .ld_data(16'h0),
        .st_req(1'b0), .st_req_ready(s_st_req_ready), .st_addr(2'd0),
        .st_valid(s_st_valid), .st_ready(1'b0), .st_data(s_st_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit              pre;
        bit              wa_en;
        logic [AW-1:0]   wa_addr;
        logic [31:0]     wa_data;
        bit              wb_en;
        logic [AW-1:0]   wb_addr;
        logic [31:0]     wb_data;
        bit              ld_en;
        logic [AW-1:0]   ld_a;
        logic [31:0]     ld_d;
        bit              rd;
        logic [AW-1:0]   ra;
        logic [AW-1:0]   rb;
        logic [VLEN-1:0] exp_a;
        logic [VLEN-1:0] exp_b;
    } vec_t;

    function automatic logic [VLEN-1:0] z(input logic [31:0] x);
        return {{(VLEN-32){1'b0}}, x};
    endfunction

    task automatic check(input string name, input logic [VLEN-1:0] act,
                         input logic [VLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [13];

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        preset = 1'b0; rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        wr_en_a = 1'b0; wr_en_b = 1'b0; wr_addr_a = '0; wr_addr_b = '0;
        wr_data_a = '0; wr_data_b = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        st_req = 1'b0; st_addr = '0; st_ready = 1'b0;
        s_rd_en = 1'b0; s_rd_addr_a = '0; s_rd_addr_b = '0;
        s_wr_en_a = 1'b0; s_wr_en_b = 1'b0; s_wr_addr_a = '0; s_wr_addr_b = '0;
        s_wr_data_a = '0; s_wr_data_b = '0;

        //               pre wa addr data     wb addr data     ld addr data       rd ra rb  exp_a        exp_b
        vecs[0]  = '{1, 0, 0, 32'h0,   0, 0, 32'h0, 1, 0, 32'h55,   1, 2, 3, z(1000),     z(2000)};
        vecs[1]  = '{0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 32'h0,    1, 0, 1, MSB,         MSB};
        vecs[2]  = '{0, 1, 1, 32'h5,   1, 1, 32'h9, 0, 0, 32'h0,    1, 1, 2, z(32'h9),    z(1000)};
        vecs[3]  = '{0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 32'h0,    1, 1, 3, z(32'h9),    z(2000)};
        vecs[4]  = '{0, 1, 1, 32'h5,   1, 1, 32'h9, 1, 1, 32'h7,    1, 1, 0, z(32'h7),    MSB};
        vecs[5]  = '{0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 32'h0,    1, 1, 1, z(32'h7),    z(32'h7)};
        vecs[6]  = '{0, 1, 2, 32'hABC, 0, 0, 32'h0, 0, 0, 32'h0,    1, 2, 2, z(32'hABC),  z(32'hABC)};
        vecs[7]  = '{0, 1, 0, 32'h11,  1, 3, 32'h33,1, 2, 32'h22,   1, 0, 3, z(32'h11),   z(32'h33)};
        vecs[8]  = '{0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 32'h0,    1, 2, 0, z(32'h22),   z(32'h11)};
        vecs[9]  = '{0, 0, 0, 32'h0,   0, 0, 32'h0, 1, 0, 32'h1234, 0, 0, 0, z(32'h22),   z(32'h11)};
        vecs[10] = '{0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 32'h0,    1, 0, 1, z(32'h1234), z(32'h7)};
        vecs[11] = '{1, 1, 0, 32'hFF,  1, 2, 32'hEE,0, 0, 32'h0,    1, 0, 1, MSB,         MSB};
        vecs[12] = '{0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 32'h0,    1, 2, 3, z(1000),     z(2000)};

        // Asynchronous reset state.
        #12;
        check("reset rd_data_a", rd_data_a, '0);
        check("reset rd_valid", z(32'(rd_valid)), '0);
        check("reset st_valid", z(32'(st_valid)), '0);
        check("reset st_data", st_data, '0);
        check("reset ld_ready", z(32'(ld_ready)), '0);
        #6;
        reset = 1'b1;
        tick();
        check("idle ld_ready", z(32'(ld_ready)), z(1));

        // Non-power-of-two instance: slot 3 does not exist.
        s_wr_en_a = 1'b1; s_wr_addr_a = 2'd3; s_wr_data_a = 16'hBEEF;
        s_rd_en = 1'b1; s_rd_addr_a = 2'd3; s_rd_addr_b = 2'd2;
        tick();
        check("oor read a", z(32'(s_rd_data_a)), '0);
        check("oor read b", z(32'(s_rd_data_b)), '0);
        s_wr_en_b = 1'b1; s_wr_addr_b = 2'd2; s_wr_data_b = 16'h0001;
        tick();
        check("oor bypass a", z(32'(s_rd_data_a)), '0);
        check("r2 bypass b", z(32'(s_rd_data_b)), z(1));
        s_wr_en_a = 1'b0; s_wr_en_b = 1'b0;
        tick();
        check("oor array a", z(32'(s_rd_data_a)), '0);
        s_rd_en = 1'b0;

        for (int i = 0; i < 13; i++) begin
            preset    = vecs[i].pre;
            wr_en_a   = vecs[i].wa_en; wr_addr_a = vecs[i].wa_addr; wr_data_a = z(vecs[i].wa_data);
            wr_en_b   = vecs[i].wb_en; wr_addr_b = vecs[i].wb_addr; wr_data_b = z(vecs[i].wb_data);
            ld_valid  = vecs[i].ld_en; ld_addr   = vecs[i].ld_a;    ld_data   = z(vecs[i].ld_d);
            rd_en     = vecs[i].rd;    rd_addr_a = vecs[i].ra;      rd_addr_b = vecs[i].rb;
            #1;
            check($sformatf("v%0d ld_ready", i), z(32'(ld_ready)), z(32'(!vecs[i].pre)));
            tick();
            check($sformatf("v%0d rd_data_a", i), rd_data_a, vecs[i].exp_a);
            check($sformatf("v%0d rd_data_b", i), rd_data_b, vecs[i].exp_b);
            check($sformatf("v%0d rd_valid", i), z(32'(rd_valid)), z(32'(vecs[i].rd)));
        end
        preset = 1'b0; wr_en_a = 1'b0; wr_en_b = 1'b0; ld_valid = 1'b0; rd_en = 1'b0;

        // Store blocked on r3 for three cycles, then back-to-back onto r2.
        st_req = 1'b1; st_addr = 2'd3; st_ready = 1'b0;
        #1;
        check("st_req_ready empty", z(32'(st_req_ready)), z(1));
        tick();
        check("st_valid r3", z(32'(st_valid)), z(1));
        check("st_data r3", st_data, z(2000));
        st_addr = 2'd1;
        for (int c = 0; c < 3; c++) begin
            check("st_req_ready full", z(32'(st_req_ready)), '0);
            tick();
            check("st_valid held", z(32'(st_valid)), z(1));
            check("st_data held", st_data, z(2000));
        end
        st_ready = 1'b1; st_addr = 2'd2;
        #1;
        check("st_req_ready drain", z(32'(st_req_ready)), z(1));
        tick();
        check("st_valid b2b", z(32'(st_valid)), z(1));
        check("st_data b2b", st_data, z(1000));
        wr_en_a = 1'b1; wr_addr_a = 2'd2; wr_data_a = z(32'h77);
        tick();
        check("st_data bypass", st_data, z(32'h77));
        wr_en_a = 1'b0; st_req = 1'b0;
        tick();
        check("st_valid drained", z(32'(st_valid)), '0);

        // Pending store killed by reset.
        st_req = 1'b1; st_addr = 2'd3; st_ready = 1'b0;
        tick();
        check("st_valid pending", z(32'(st_valid)), z(1));
        st_req = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async st_valid", z(32'(st_valid)), '0);
        check("async st_data", st_data, '0);
        check("async rd_data_b", rd_data_b, '0);
        check("async ld_ready", z(32'(ld_ready)), '0);
        #3;
        reset = 1'b1;
        rd_en = 1'b1; rd_addr_a = 2'd0; rd_addr_b = 2'd1;
        tick();
        check("post rst r0", rd_data_a, '0);
        check("post rst r1", rd_data_b, '0);
        rd_addr_a = 2'd2; rd_addr_b = 2'd3;
        tick();
        check("post rst r2", rd_data_a, '0);
        check("post rst r3", rd_data_b, '0);
        check("post rst st_valid", z(32'(st_valid)), '0);
        rd_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
